// File: rtl/lcd_spi_serializer_if.sv
// Word handshake and SPI pin bundle between the LCD word generators and the serializer.
// The generator holds the master side; the serializer holds the slave side.
interface lcd_spi_serializer_if;
  logic [8:0] data;
  logic       en_write;
  logic       sclk;
  logic       mosi;
  logic       cs;
  logic       dc;
  logic       wr_done;
  logic       busy;

  modport master (
    output data,
    output en_write,
    input  sclk,
    input  mosi,
    input  cs,
    input  dc,
    input  wr_done,
    input  busy
  );

  modport slave (
    input  data,
    input  en_write,
    output sclk,
    output mosi,
    output cs,
    output dc,
    output wr_done,
    output busy
  );
endinterface

// File: rtl/lcd_spi_serializer.sv
// SPI mode-0 byte transmitter for an ST7789-class LCD: one {dc, byte} word per cs frame,
// sent MSB first. Every output comes straight from a flop.
module lcd_spi_serializer #(
  parameter int CLK_DIV = 2
) (
  input  logic                 sys_clk_50MHz,
  input  logic                 sys_rst_n,
  lcd_spi_serializer_if.slave  bus
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  state_t           state_q, state_n;
  logic [7:0]       byte_q, byte_n;
  logic [2:0]       bit_idx_q, bit_idx_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic             cs_q, cs_n;
  logic             sclk_q, sclk_n;
  logic             mosi_q, mosi_n;
  logic             dc_q, dc_n;
  logic             wr_done_q, wr_done_n;
  logic             busy_q, busy_n;

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte_q    <= '0;
      bit_idx_q <= '0;
      div_q     <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      dc_q      <= 1'b0;
      wr_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      byte_q    <= byte_n;
      bit_idx_q <= bit_idx_n;
      div_q     <= div_n;
      cs_q      <= cs_n;
      sclk_q    <= sclk_n;
      mosi_q    <= mosi_n;
      dc_q      <= dc_n;
      wr_done_q <= wr_done_n;
      busy_q    <= busy_n;
    end
  end

  // Next values of every output flop are computed here so each output stays registered.
  always_comb begin
    state_n   = state_q;
    byte_n    = byte_q;
    bit_idx_n = bit_idx_q;
    div_n     = div_q;
    cs_n      = cs_q;
    sclk_n    = sclk_q;
    mosi_n    = mosi_q;
    dc_n      = dc_q;
    wr_done_n = 1'b0;
    busy_n    = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.en_write) begin
          byte_n    = bus.data[7:0];
          dc_n      = bus.data[8];
          mosi_n    = bus.data[7];
          cs_n      = 1'b0;
          sclk_n    = 1'b0;
          bit_idx_n = 3'd7;
          div_n     = DIV_LOAD;
          busy_n    = 1'b1;
          state_n   = SHIFT;
        end
      end

      SHIFT: begin
        if (div_q != '0) begin
          div_n = div_q - DIV_W'(1);
        end else begin
          div_n = DIV_LOAD;
          if (!sclk_q) begin
            sclk_n = 1'b1;
          end else begin
            // Falling edge: present the next bit, or leave after bit 0 without wrapping.
            sclk_n = 1'b0;
            if (bit_idx_q != 3'd0) begin
              mosi_n    = byte_q[bit_idx_q - 3'd1];
              bit_idx_n = bit_idx_q - 3'd1;
            end else begin
              state_n = HOLD;
            end
          end
        end
      end

      HOLD: begin
        if (div_q != '0) begin
          div_n = div_q - DIV_W'(1);
        end else begin
          cs_n      = 1'b1;
          wr_done_n = 1'b1;
          state_n   = DONE;
        end
      end

      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.cs      = cs_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.dc      = dc_q;
  assign bus.wr_done = wr_done_q;
  assign bus.busy    = busy_q;

endmodule
